// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one combinational 8-bit ALU between N_REQ requesters.
// One operation in flight: IDLE grants, EXEC holds ALU inputs, RESP waits on the response channel.
module alu_req_arbiter #(
  parameter int          N_REQ        = 2,
  parameter int          EXEC_CYC     = 1,
  parameter logic [15:0] OP_COUNT_RST = 16'h0000,
  localparam int         ID_W         = (N_REQ == 2) ? 1 : 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [8*N_REQ-1:0] req_a,
  input  logic [8*N_REQ-1:0] req_b,
  input  logic [4*N_REQ-1:0] req_sel,
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  output logic [3:0]         alu_sel,
  input  logic [7:0]         alu_result,
  input  logic [3:0]         alu_flags,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [7:0]         rsp_result,
  output logic [3:0]         rsp_flags,
  output logic               rsp_err,
  output logic [15:0]        op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        alu_a_q, alu_a_d;
  logic [7:0]        alu_b_q, alu_b_d;
  logic [3:0]        alu_sel_q, alu_sel_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [7:0]        rsp_result_q, rsp_result_d;
  logic [3:0]        rsp_flags_q, rsp_flags_d;
  logic              rsp_err_q, rsp_err_d;
  logic [15:0]       op_count_q, op_count_d;

  logic [7:0]        a_arr   [N_REQ];
  logic [7:0]        b_arr   [N_REQ];
  logic [3:0]        sel_arr [N_REQ];
  logic              gnt_found;
  logic [ID_W-1:0]   gnt_idx;
  logic              grant_en;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign a_arr[gi]     = req_a[8*gi +: 8];
      assign b_arr[gi]     = req_b[8*gi +: 8];
      assign sel_arr[gi]   = req_sel[4*gi +: 4];
      assign req_ready[gi] = grant_en && (gnt_idx == ID_W'(gi));
    end
  endgenerate

  // Search starts just after the last served requester, wrapping modulo N_REQ.
  always_comb begin
    logic [ID_W-1:0] cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((int'(ptr_q) + k) % N_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // No grant is offered while reset is held, even though the state already reads IDLE.
  assign grant_en = (state_q == IDLE) && gnt_found && !reset;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_err_d    = rsp_err_q;
    op_count_d   = op_count_q;
    case (state_q)
      IDLE: begin
        if (grant_en) begin
          alu_a_d   = a_arr[gnt_idx];
          alu_b_d   = b_arr[gnt_idx];
          alu_sel_d = sel_arr[gnt_idx];
          id_d      = gnt_idx;
          cnt_d     = 4'(EXEC_CYC);
          state_d   = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd1) begin
          rsp_result_d = alu_result;
          rsp_flags_d  = alu_flags;
          rsp_err_d    = (alu_sel_q > 4'hA) || ((alu_sel_q == 4'h3) && (alu_b_q == 8'h00));
          rsp_id_d     = id_q;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          ptr_d       = id_q;
          op_count_d  = op_count_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= ID_W'(N_REQ - 1);
      id_q         <= '0;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
      op_count_q   <= OP_COUNT_RST;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_err_q    <= rsp_err_d;
      op_count_q   <= op_count_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: directed vector table, multi-cycle corner sequences and a
// randomized run checked against a transaction-level model; a stand-in ALU closes the loop.
module tb_alu_req_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Stand-in ALU; flags are {C,V,Z,N}.
  function automatic logic [11:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    logic [8:0] w;
    logic [7:0] r;
    logic       c, v;
    w = '0; r = '0; c = 1'b0; v = 1'b0;
    case (s)
      4'h0: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      4'h1: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
      4'h2: r = 8'(a * b);
      4'h3: r = (b == 8'h00) ? 8'h00 : a / b;
      4'h4: r = a & b;
      4'h5: r = a | b;
      4'h6: r = a ^ b;
      4'h7: r = ~a;
      4'h8: r = {a[6:0], 1'b0};
      4'h9: r = {1'b0, a[7:1]};
      4'hA: r = a;
      default: r = 8'h00;
    endcase
    return {r, c, v, (r == 8'h00), r[7]};
  endfunction

  function automatic logic bit_of(input logic [1:0] v, input int i);
    return (i == 0) ? v[0] : v[1];
  endfunction

  function automatic logic [1:0] onehot(input int i);
    return (i == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- DUT with EXEC_CYC=1 ----------------
  logic [1:0]  req_valid1, req_ready1;
  logic [15:0] req_a1, req_b1;
  logic [7:0]  req_sel1;
  logic [7:0]  alu_a1, alu_b1, alu_result1, rsp_result1;
  logic [3:0]  alu_sel1, alu_flags1, rsp_flags1;
  logic        rsp_valid1, rsp_ready1, rsp_err1;
  logic [0:0]  rsp_id1;
  logic [15:0] op_count1;

  assign {alu_result1, alu_flags1} = alu_f(alu_a1, alu_b1, alu_sel1);

  alu_req_arbiter #(.N_REQ(2), .EXEC_CYC(1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid1), .req_ready(req_ready1),
    .req_a(req_a1), .req_b(req_b1), .req_sel(req_sel1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_sel(alu_sel1),
    .alu_result(alu_result1), .alu_flags(alu_flags1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_id(rsp_id1),
    .rsp_result(rsp_result1), .rsp_flags(rsp_flags1), .rsp_err(rsp_err1),
    .op_count(op_count1)
  );

  // ---------------- DUT with EXEC_CYC=3, counter preloaded near wrap ----------------
  logic [1:0]  req_valid3, req_ready3;
  logic [15:0] req_a3, req_b3;
  logic [7:0]  req_sel3;
  logic [7:0]  alu_a3, alu_b3, alu_result3, rsp_result3;
  logic [3:0]  alu_sel3, alu_flags3, rsp_flags3;
  logic        rsp_valid3, rsp_ready3, rsp_err3;
  logic [0:0]  rsp_id3;
  logic [15:0] op_count3;

  assign {alu_result3, alu_flags3} = alu_f(alu_a3, alu_b3, alu_sel3);

  alu_req_arbiter #(.N_REQ(2), .EXEC_CYC(3), .OP_COUNT_RST(16'hFFFE)) dut3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3), .req_sel(req_sel3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_sel(alu_sel3),
    .alu_result(alu_result3), .alu_flags(alu_flags3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_id(rsp_id3),
    .rsp_result(rsp_result3), .rsp_flags(rsp_flags3), .rsp_err(rsp_err3),
    .op_count(op_count3)
  );

  typedef struct {
    logic [3:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] flg;
    logic       err;
  } vec_t;

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] s;
  } txn_t;

  vec_t        vt [9];
  logic [15:0] exp_cnt;
  int          nxt;
  logic [1:0]  e_rdy;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid1 = '0; req_a1 = '0; req_b1 = '0; req_sel1 = '0; rsp_ready1 = 1'b0;
    req_valid3 = '0; req_a3 = '0; req_b3 = '0; req_sel3 = '0; rsp_ready3 = 1'b0;

    vt[0] = '{4'h0, 8'h7F, 8'h01, 8'h80, 4'b0101, 1'b0};
    vt[1] = '{4'h0, 8'hFF, 8'h01, 8'h00, 4'b1010, 1'b0};
    vt[2] = '{4'h3, 8'h10, 8'h00, 8'h00, 4'b0010, 1'b1};
    vt[3] = '{4'h3, 8'h10, 8'h04, 8'h04, 4'b0000, 1'b0};
    vt[4] = '{4'hF, 8'h12, 8'h34, 8'h00, 4'b0010, 1'b1};
    vt[5] = '{4'hB, 8'h01, 8'h01, 8'h00, 4'b0010, 1'b1};
    vt[6] = '{4'hA, 8'h55, 8'h00, 8'h55, 4'b0000, 1'b0};
    vt[7] = '{4'h4, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1'b0};
    vt[8] = '{4'h6, 8'hAA, 8'hAA, 8'h00, 4'b0010, 1'b0};

    // Reset state, with requests already pending
    repeat (2) @(negedge clk);
    req_valid1 = 2'b11;
    #1;
    chk("rst_ready", 32'(req_ready1), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid1), 32'd0);
    chk("rst_alu", 32'({alu_a1, alu_b1, alu_sel1}), 32'd0);
    chk("rst_rsp", 32'({rsp_id1, rsp_result1, rsp_flags1, rsp_err1}), 32'd0);
    chk("rst_op_count", 32'(op_count1), 32'd0);
    chk("rst_op_count3", 32'(op_count3), 32'hFFFE);
    req_valid1 = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 16'd0;

    // Vector table on requester 0
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      req_valid1 = 2'b01; req_a1 = {8'h00, vt[i].a}; req_b1 = {8'h00, vt[i].b};
      req_sel1 = {4'h0, vt[i].sel}; rsp_ready1 = 1'b1;
      #1;
      chk("tbl_ready", 32'(req_ready1), 32'd1);
      @(negedge clk);
      req_valid1 = 2'b00;
      #1;
      chk("tbl_exec_no_rsp", 32'(rsp_valid1), 32'd0);
      chk("tbl_alu_in", 32'({alu_a1, alu_b1, alu_sel1}), 32'({vt[i].a, vt[i].b, vt[i].sel}));
      @(negedge clk);
      #1;
      chk("tbl_rsp_valid", 32'(rsp_valid1), 32'd1);
      chk("tbl_result", 32'(rsp_result1), 32'(vt[i].res));
      chk("tbl_flags", 32'(rsp_flags1), 32'(vt[i].flg));
      chk("tbl_err", 32'(rsp_err1), 32'(vt[i].err));
      chk("tbl_id", 32'(rsp_id1), 32'd0);
      @(negedge clk);
      #1;
      exp_cnt = exp_cnt + 16'd1;
      chk("tbl_rsp_done", 32'(rsp_valid1), 32'd0);
      chk("tbl_op_count", 32'(op_count1), 32'(exp_cnt));
      $display("vec %0d sel=%h a=%h b=%h -> result=%h flags=%b err=%0d", i, vt[i].sel, vt[i].a, vt[i].b,
               rsp_result1, rsp_flags1, rsp_err1);
    end

    // Both requesters valid continuously: grants alternate, last served was 0
    nxt = 1;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      req_valid1 = 2'b11; req_a1 = 16'h0201; req_b1 = 16'h0101; req_sel1 = 8'h00; rsp_ready1 = 1'b1;
      #1;
      e_rdy = (k % 3 == 0) ? onehot(nxt) : 2'b00;
      chk("alt_grant", 32'(req_ready1), 32'(e_rdy));
      if (k % 3 == 2) chk("alt_rsp_id", 32'(rsp_id1), 32'(nxt));
      if (k % 3 == 2) begin
        $display("alt grant id=%0d result=%h", nxt, rsp_result1);
        nxt = 1 - nxt;
      end
    end
    @(negedge clk);
    req_valid1 = 2'b00;
    #1;
    exp_cnt = exp_cnt + 16'd6;
    chk("alt_op_count", 32'(op_count1), 32'(exp_cnt));

    // Backpressure: response held 5 cycles, no new grant, ALU inputs steady
    @(negedge clk);
    req_valid1 = 2'b01; req_a1 = 16'h0021; req_b1 = 16'h0012; req_sel1 = 8'h00; rsp_ready1 = 1'b0;
    #1;
    chk("bp_grant", 32'(req_ready1), 32'd1);
    @(negedge clk);
    req_valid1 = 2'b11; req_a1 = 16'hEEEE;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      if (k == 5) rsp_ready1 = 1'b1;
      #1;
      chk("bp_rsp_valid", 32'(rsp_valid1), 32'd1);
      chk("bp_rsp", 32'({rsp_id1, rsp_result1, rsp_flags1, rsp_err1}), 32'({1'b0, 8'h33, 4'b0000, 1'b0}));
      chk("bp_ready", 32'(req_ready1), 32'd0);
      chk("bp_alu", 32'({alu_a1, alu_b1, alu_sel1}), 32'({8'h21, 8'h12, 4'h0}));
      @(negedge clk);
    end
    req_valid1 = 2'b00;
    #1;
    exp_cnt = exp_cnt + 16'd1;
    chk("bp_op_count", 32'(op_count1), 32'(exp_cnt));
    $display("backpressure op result=%h count=%0d", 8'h33, op_count1);

    // Reset in EXEC: requester 1 is next in line, reset must restore requester 0 priority
    @(negedge clk);
    req_valid1 = 2'b11;
    #1;
    chk("rm_grant", 32'(req_ready1), 32'd2);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rm_rsp_valid", 32'(rsp_valid1), 32'd0);
    chk("rm_ready", 32'(req_ready1), 32'd0);
    chk("rm_op_count", 32'(op_count1), 32'd0);
    @(negedge clk);
    #1;
    chk("rm_ready_held", 32'(req_ready1), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rm_rr_restart", 32'(req_ready1), 32'd1);
    @(negedge clk);
    req_valid1 = 2'b00;
    #1;
    chk("rm_no_stale_rsp", 32'(rsp_valid1), 32'd0);
    repeat (3) @(negedge clk);
    $display("reset-in-exec recovered, op_count=%0d", op_count1);

    // EXEC_CYC=3 latency and counter wrap FFFE -> FFFF -> 0000
    for (int op = 0; op < 2; op++) begin
      @(negedge clk);
      req_valid3 = (op == 0) ? 2'b01 : 2'b10;
      req_a3 = 16'h0503; req_b3 = 16'h0604; req_sel3 = 8'h00; rsp_ready3 = 1'b1;
      #1;
      chk("e3_grant", 32'(req_ready3), 32'(onehot(op)));
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        req_valid3 = 2'b00;
        #1;
        chk("e3_latency", 32'(rsp_valid3), (k == 4) ? 32'd1 : 32'd0);
      end
      chk("e3_result", 32'(rsp_result3), (op == 0) ? 32'h07 : 32'h0B);
      chk("e3_id", 32'(rsp_id3), 32'(op));
      @(negedge clk);
      #1;
      chk("e3_op_count", 32'(op_count3), (op == 0) ? 32'hFFFF : 32'h0000);
      $display("exec3 op %0d result=%h op_count=%h", op, rsp_result3, op_count3);
    end

    // Randomized traffic against a transaction-level model
    do_reset();
    begin
      txn_t       q[$];
      txn_t       t;
      int         last, cyc, hs_cyc;
      logic [7:0] ra0, ra1, rb0, rb1, la, lb;
      logic [3:0] rs0, rs1, ls;
      logic [1:0] rv, er;
      logic       erv;
      logic [11:0] ar;
      last = 1; cyc = 0; hs_cyc = 0; exp_cnt = 16'd0;
      la = '0; lb = '0; ls = '0;
      for (int n = 0; n < 3000; n++) begin
        @(negedge clk);
        rv  = 2'($urandom_range(0, 3));
        ra0 = 8'($urandom); ra1 = 8'($urandom);
        rb0 = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        rb1 = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        rs0 = 4'($urandom); rs1 = 4'($urandom);
        req_valid1 = rv; req_a1 = {ra1, ra0}; req_b1 = {rb1, rb0}; req_sel1 = {rs1, rs0};
        rsp_ready1 = ($urandom_range(0, 2) != 0);
        #1;
        er = 2'b00;
        if (q.size() == 0) begin
          for (int k = 1; k <= 2; k++) begin
            int c;
            c = (last + k) % 2;
            if (er == 2'b00 && bit_of(rv, c)) er = onehot(c);
          end
        end
        erv = (q.size() != 0) && (cyc - hs_cyc >= 2);
        chk("rnd_ready", 32'(req_ready1), 32'(er));
        chk("rnd_rsp_valid", 32'(rsp_valid1), 32'(erv));
        chk("rnd_alu", 32'({alu_a1, alu_b1, alu_sel1}), 32'({la, lb, ls}));
        chk("rnd_op_count", 32'(op_count1), 32'(exp_cnt));
        if (erv) begin
          t  = q[0];
          ar = alu_f(t.a, t.b, t.s);
          chk("rnd_result", 32'(rsp_result1), 32'(ar[11:4]));
          chk("rnd_flags", 32'(rsp_flags1), 32'(ar[3:0]));
          chk("rnd_err", 32'(rsp_err1), 32'((t.s > 4'hA) || (t.s == 4'h3 && t.b == 8'h00)));
          chk("rnd_id", 32'(rsp_id1), 32'(t.id));
          if (rsp_ready1) begin
            void'(q.pop_front());
            last = t.id;
            exp_cnt = exp_cnt + 16'd1;
          end
        end
        if (er != 2'b00) begin
          t.id = (er == 2'b01) ? 0 : 1;
          t.a  = (t.id == 0) ? ra0 : ra1;
          t.b  = (t.id == 0) ? rb0 : rb1;
          t.s  = (t.id == 0) ? rs0 : rs1;
          q.push_back(t);
          la = t.a; lb = t.b; ls = t.s;
          hs_cyc = cyc;
        end
        cyc++;
      end
      $display("random run done: %0d responses", exp_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
